// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between EX-stage control and the HI/LO unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic start, abort, busy, done;
    logic [2:0] op;
    logic [WIDTH-1:0] in1, in2, hi, lo;
    modport master(output start, op, in1, in2, abort, input busy, done, hi, lo);
    modport slave(input start, op, in1, in2, abort, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU over magnitudes with sign fix-up, plus MTHI/MTLO
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d, prod;
    logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d, m1, m2, quo, rem;
    logic div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, done_q, done_d;
    logic go, sgn;
    logic [WIDTH:0] sum, t, diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            p_q <= '0;
            a_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            div_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            p_q <= p_d;
            a_q <= a_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            div_q <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q <= done_d;
        end
    end

    assign go = bus.start && !bus.abort && state_q == IDLE;
    assign sgn = !bus.op[0];

    always_comb begin
        state_d = bus.abort ? IDLE :
                  state_q == IDLE ? ((go && !bus.op[2]) ? CALC : IDLE) :
                  state_q == CALC ? ((cnt_q == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end

    // p_q holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign m1 = (sgn && bus.in1[WIDTH-1]) ? -bus.in1 : bus.in1;
    assign m2 = (sgn && bus.in2[WIDTH-1]) ? -bus.in2 : bus.in2;
    assign sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    assign t = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign diff = t - {1'b0, a_q};
    assign prod = neg_res_q ? -p_q : p_q;
    assign quo = neg_res_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        cnt_d = cnt_q;
        p_d = p_q;
        a_d = a_q;
        div_d = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d = 1'b0;
        hi_d = (go && bus.op == 3'd4) ? bus.in1 : hi_q;
        lo_d = (go && bus.op == 3'd5) ? bus.in1 : lo_q;
        if (go && !bus.op[2]) begin
            cnt_d = '0;
            p_d = {{WIDTH{1'b0}}, m1};
            a_d = m2;
            div_d = bus.op[1];
            // a zero divisor keeps the quotient positive so LO comes out all ones
            neg_res_d = sgn && (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]) && (!bus.op[1] || |bus.in2);
            neg_rem_d = sgn && bus.op[1] && bus.in1[WIDTH-1];
        end
        if (state_q == CALC) begin
            cnt_d = cnt_q + CW'(1);
            p_d = !div_q ? {sum, p_q[WIDTH-1:1]} :
                  diff[WIDTH] ? {t[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0} :
                  {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end
        if (state_q == FIX && !bus.abort) begin
            hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d = div_q ? quo : prod[WIDTH-1:0];
            done_d = 1'b1;
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.done = done_q;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the EX stage of the MIPS pipeline. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds the results in the architectural HI/LO registers. It also services MTHI/MTLO writes. It exposes a busy/done handshake so hazard logic can stall MFHI/MFLO and later mult/div instructions while an operation is in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 = no-op
- in1  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
- in2  input  WIDTH  rt operand (multiplier / divisor)
- abort  input  1  pipeline flush; cancels an in-flight operation
- busy  output  1  high while an operation is in CALC or FIX
- done  output  1  one-cycle pulse when HI/LO receive a new mult/div result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op 0-3:
  - Latch operand magnitudes: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - Latch the result-sign and remainder-sign flags.
  - Clear the iteration counter and go to CALC.
- IDLE, start=1, op 4/5: write in1 into HI (op 4) or LO (op 5) at that edge. Stay in IDLE; busy and done stay 0.
- IDLE, start=1, op 6/7: ignored.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, with a (WIDTH+1)-bit partial remainder.
- CALC ends after exactly WIDTH iterations; the unit then goes to FIX.
- FIX, multiply: negate the 2·WIDTH product if sign flag set. HI = upper WIDTH bits, LO = lower WIDTH bits.
- FIX, divide:
  - LO = quotient, negated if the operand signs differ (signed ops only).
  - HI = remainder, negated if the dividend is negative (signed ops only).
  - Remainder sign always follows the dividend.
- FIX always finishes by pulsing done and returning to IDLE.
- Divide by zero (in2=0, DIV or DIVU): the normal WIDTH-cycle latency is kept. Result is LO = all ones, HI = in1 unmodified.
- Signed overflow (DIV of 100..0 by all ones): falls out of the magnitude arithmetic as LO = 100..0, HI = 0. No trap.
- All arithmetic is modulo 2^WIDTH per register. Overflow is never flagged.
- start while busy=1 is ignored, including MTHI/MTLO; hazard logic must stall.
- abort=1:
  - In CALC or FIX: go to IDLE at the next edge. HI/LO unchanged, no done pulse, busy=0 after that edge.
  - In IDLE: abort takes priority over start; the request is dropped.

## Timing
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Takes effect immediately, independent of clk. Mid-operation reset discards the operation.
- start accepted at edge E0 → busy=1 from E0.
- CALC spans edges E1..E_WIDTH. FIX edge is E_{WIDTH+1}.
- At E_{WIDTH+1}: hi/lo updated, done=1, busy=0.
- Latency from accepting edge to valid result is WIDTH+1 edges (33 for WIDTH=32).
- done is high for exactly one cycle and is low after the following edge.
- A start seen in the done cycle (busy=0) is accepted, so back-to-back ops run every WIDTH+1 cycles.
- MTHI/MTLO: the register is visible on hi/lo the cycle after the accepting edge.
- hi/lo hold their value throughout CALC. MFHI/MFLO read the old value unless stalled on busy.

## Test plan
- MULT, in1=FFFFFFFD (-3), in2=00000005 → after 33 edges: hi=FFFFFFFF, lo=FFFFFFF1, done pulses once, busy high for edges 1-32.
- MULTU, in1=in2=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Repeat as MULT → hi=00000000, lo=00000001.
- DIV, in1=FFFFFFF9 (-7), in2=00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- Corner divides:
  - DIVU 7/0 → lo=FFFFFFFF, hi=00000007 after 33 edges.
  - DIV 80000000/FFFFFFFF → lo=80000000, hi=00000000.
- Control interference:
  - Second start at edge 5 of a MULT is ignored; the result matches the first op.
  - abort at edge 10 → busy drops, no done, hi/lo keep the prior values.
  - MTHI 12345678 in IDLE → hi=12345678 next cycle, done stays 0.
- Async reset asserted mid-CALC between clock edges → hi=lo=0, busy=0 immediately. A new MULT after release completes normally in 33 edges.
